// File: rtl/digit_scan_driver.sv
// Time-multiplexed hex display driver: scans DIGITS common-anode digits,
// one slot of REFRESH_DIV clocks each, from a snapshot of hex_in/dp_in
// taken once per frame so that a frame never mixes two input samples.
//
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   hex_in         4*DIGITS nibbles, digit 0 in the low nibble (rightmost)
//   dp_in          decimal point request per digit, 1 = lit
//   blank_lz       1 = blank leading zero digits (digit 0 never blanked)
//   enable         1 = scan runs; 0 = freeze scan, display dark
//   an             digit strobes, active-low, one-hot-low while scanning
//   seg            segments {g,f,e,d,c,b,a}, active-low
//   dp             decimal point, active-low
//   digit_sel      index of the digit currently driven
//   bcd_out        nibble currently driven, before blanking
//   frame_tick     one-cycle pulse when the scan wraps to digit 0
module digit_scan_driver #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [4*DIGITS-1:0]         hex_in,
  input  logic [DIGITS-1:0]           dp_in,
  input  logic                        blank_lz,
  input  logic                        enable,
  output logic [DIGITS-1:0]           an,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [$clog2(DIGITS)-1:0]   digit_sel,
  output logic [3:0]                  bcd_out,
  output logic                        frame_tick
);

  localparam int unsigned SEL_W = $clog2(DIGITS);
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned HEX_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);

  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  idx;
  logic [HEX_W-1:0]  snap_hex;
  logic [DIGITS-1:0] snap_dp;
  logic              load_pending;

  logic              slot_tick_c;
  logic              wrap_c;
  logic              load_c;
  logic [HEX_W-1:0]  cur_hex_c;
  logic [DIGITS-1:0] cur_dp_c;
  logic [3:0]        nib_c;
  logic              dp_bit_c;
  logic              nonzero_c;
  logic              blank_c;

  // Standard active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan control plus current-digit selection. On a load cycle the fresh
  // sample is used directly so the first digit of a frame already shows it.
  always_comb begin
    slot_tick_c = enable && (cnt == CNT_LAST);
    wrap_c      = slot_tick_c && (idx == IDX_LAST);
    load_c      = load_pending && enable;
    cur_hex_c   = load_c ? hex_in : snap_hex;
    cur_dp_c    = load_c ? dp_in  : snap_dp;
    nib_c       = 4'h0;
    dp_bit_c    = 1'b0;
    nonzero_c   = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (SEL_W'(k) == idx) begin
        nib_c    = cur_hex_c[4*k +: 4];
        dp_bit_c = cur_dp_c[k];
      end
      // Any nonzero nibble at or above the current digit keeps it visible.
      if ((SEL_W'(k) >= idx) && (cur_hex_c[4*k +: 4] != 4'h0)) begin
        nonzero_c = 1'b1;
      end
    end
    blank_c = blank_lz && (idx != '0) && !nonzero_c;
  end

  // Scan state, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      snap_hex     <= '0;
      snap_dp      <= '0;
      load_pending <= 1'b1;
      an           <= '1;
      seg          <= 7'b1111111;
      dp           <= 1'b1;
      digit_sel    <= '0;
      bcd_out      <= 4'h0;
      frame_tick   <= 1'b0;
    end else begin
      if (enable) begin
        cnt <= slot_tick_c ? '0 : cnt + CNT_W'(1);
        if (slot_tick_c) begin
          idx <= wrap_c ? '0 : idx + SEL_W'(1);
        end
      end
      if (load_c) begin
        snap_hex     <= hex_in;
        snap_dp      <= dp_in;
        load_pending <= 1'b0;
      end
      // A wrap re-arms the load even if enable drops right after it.
      if (wrap_c) begin
        load_pending <= 1'b1;
      end
      frame_tick <= wrap_c;
      digit_sel  <= idx;
      bcd_out    <= nib_c;
      if (enable) begin
        an  <= ~(DIGITS'(1) << idx);
        seg <= blank_c ? 7'b1111111 : seg_decode(nib_c);
        dp  <= blank_c ? 1'b1 : ~dp_bit_c;
      end else begin
        an  <= '1;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver with DIGITS=4, REFRESH_DIV=4:
// a table of static display patterns checked over a full frame, plus
// hand-written sequences for frame tick, enable gating and reset.
module tb_digit_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        enable;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic [3:0]  bcd_out;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .enable     (enable),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .bcd_out    (bcd_out),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dpi;
    logic        blz;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
    logic [3:0]  dpo;   // expected active-low dp per digit
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_sel", 32'(digit_sel), 32'h0);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_ft", 32'(frame_tick), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         d;

    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h3800, 4'b0100, 1'b0, {7'b0110000, 7'b0000000, 7'b1000000, 7'b1000000}, 4'b1011};
    vecs[4] = '{16'h0001, 4'b0100, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111001}, 4'b1111};
    vecs[5] = '{16'h0C09, 4'b1111, 1'b1, {7'b1111111, 7'b1000110, 7'b1000000, 7'b0010000}, 4'b1000};
    vecs[6] = '{16'h7E6B, 4'b1000, 1'b1, {7'b1111000, 7'b0000110, 7'b0000010, 7'b0000011}, 4'b0111};
    vecs[7] = '{16'h4D95, 4'b0001, 1'b0, {7'b0011001, 7'b0100001, 7'b0010000, 7'b0010010}, 4'b1110};

    reset    = 1'b1;
    hex_in   = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    enable   = 1'b1;
    @(negedge clk);

    // Static patterns: every edge of the first frame after reset release.
    for (int v = 0; v < 8; v++) begin
      hex_in   = vecs[v].hex;
      dp_in    = vecs[v].dpi;
      blank_lz = vecs[v].blz;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
        tick();
        d       = (k - 1) / 4;
        exp_an  = ~(4'b0001 << d);
        exp_seg = vecs[v].segs[7*d +: 7];
        check($sformatf("v%0d_e%0d_an", v, k), 32'(an), 32'(exp_an));
        check($sformatf("v%0d_e%0d_seg", v, k), 32'(seg), 32'(exp_seg));
        check($sformatf("v%0d_e%0d_dp", v, k), 32'(dp), 32'(vecs[v].dpo[d]));
        check($sformatf("v%0d_e%0d_sel", v, k), 32'(digit_sel), 32'(d));
        check($sformatf("v%0d_e%0d_bcd", v, k), 32'(bcd_out), 32'(vecs[v].hex[4*d +: 4]));
        check($sformatf("v%0d_e%0d_ft", v, k), 32'(frame_tick), (k == 16) ? 32'h1 : 32'h0);
      end
    end

    // Frame tick period and mid-frame input change.
    hex_in = 16'h12AF; dp_in = 4'h0; blank_lz = 1'b0; enable = 1'b1;
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      tick();
      check($sformatf("ft_e%0d", k), 32'(frame_tick), ((k % 16) == 0) ? 32'h1 : 32'h0);
      if (k == 10) check("ft_mid_seg2", 32'(seg), 32'h24);
      if (k == 14) check("ft_mid_seg3", 32'(seg), 32'h79);
      if (k == 17) begin
        check("ft_new_an", 32'(an), 32'hE);
        check("ft_new_seg", 32'(seg), 32'h40);
      end
      if (k == 6) hex_in = 16'h0000;
    end

    // Enable gating mid-slot.
    hex_in = 16'h12AF;
    do_reset();
    for (int k = 1; k <= 6; k++) tick();
    check("en_pre_an", 32'(an), 32'hD);
    enable = 1'b0;
    for (int k = 7; k <= 16; k++) begin
      tick();
      check($sformatf("en_off_e%0d_an", k), 32'(an), 32'hF);
      check($sformatf("en_off_e%0d_dp", k), 32'(dp), 32'h1);
      check($sformatf("en_off_e%0d_ft", k), 32'(frame_tick), 32'h0);
      check($sformatf("en_off_e%0d_sel", k), 32'(digit_sel), 32'h1);
    end
    enable = 1'b1;
    tick();
    check("en_on1_an", 32'(an), 32'hD);
    check("en_on1_seg", 32'(seg), 32'h08);
    tick();
    check("en_on2_an", 32'(an), 32'hD);
    tick();
    check("en_on3_an", 32'(an), 32'hB);
    check("en_on3_seg", 32'(seg), 32'h24);

    // Reset asserted mid-scan, then a clean restart.
    do_reset();
    for (int k = 1; k <= 9; k++) tick();
    check("mr_pre_an", 32'(an), 32'hB);
    reset = 1'b1;
    tick();
    check("mr_an", 32'(an), 32'hF);
    check("mr_sel", 32'(digit_sel), 32'h0);
    check("mr_seg", 32'(seg), 32'h7F);
    check("mr_dp", 32'(dp), 32'h1);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("mr_e%0d_an", k), 32'(an), (k <= 4) ? 32'hE : 32'hD);
      check($sformatf("mr_e%0d_seg", k), 32'(seg), (k <= 4) ? 32'h0E : 32'h08);
    end

    // Wrap coinciding with enable falling: load deferred to next enabled edge.
    do_reset();
    for (int k = 1; k <= 15; k++) tick();
    hex_in = 16'h4D95;
    tick();
    check("co_ft", 32'(frame_tick), 32'h1);
    enable = 1'b0;
    tick();
    check("co_off_ft", 32'(frame_tick), 32'h0);
    check("co_off_an", 32'(an), 32'hF);
    check("co_off_sel", 32'(digit_sel), 32'h0);
    tick();
    hex_in = 16'h7E6B;
    tick();
    enable = 1'b1;
    tick();
    check("co_load_an", 32'(an), 32'hE);
    check("co_load_seg", 32'(seg), 32'h03);
    check("co_load_bcd", 32'(bcd_out), 32'hB);
    hex_in = 16'h0000;
    tick();
    check("co_hold_seg", 32'(seg), 32'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
